// File: rtl/div_share_ctrl.sv
// Round-robin front end that shares a single divider core among N requesters.
// It latches the winner's operands, starts the core, counts its fixed latency and returns results with an ack pulse.
module div_share_ctrl #(
   parameter int N       = 4,
   parameter int W       = 16,
   parameter int DIV_LAT = 16,
   parameter int IDW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N-1:0]   req_i,
   input  logic [N*W-1:0] x_bus_i,
   input  logic [N*W-1:0] y_bus_i,
   output logic [N-1:0]   ack_o,
   output logic [W-1:0]   res_q_o,
   output logic [W-1:0]   res_r_o,
   output logic [IDW-1:0] res_id_o,
   output logic           res_dz_o,
   output logic           busy_o,
   output logic           div_start_o,
   output logic [W-1:0]   div_x_o,
   output logic [W-1:0]   div_y_o,
   input  logic [W-1:0]   div_q_i,
   input  logic [W-1:0]   div_r_i
);

   localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [IDW-1:0] rrPtr_q, rrPtr_d;
   logic [IDW-1:0] curId_q, curId_d;
   logic [IDW-1:0] resId_q, resId_d;
   logic [W-1:0]   divX_q, divX_d;
   logic [W-1:0]   divY_q, divY_d;
   logic [W-1:0]   resQuot_q, resQuot_d;
   logic [W-1:0]   resRem_q, resRem_d;
   logic           resDz_q, resDz_d;
   logic [N-1:0]   ack_q, ack_d;
   logic           divStart_q, divStart_d;

   logic           grantValid;
   logic [IDW-1:0] grantId;
   logic [W-1:0]   selX;
   logic [W-1:0]   selY;

   // Scan downward so the lowest offset from the round-robin pointer wins last.
   always_comb begin
      int idx;
      idx        = 0;
      grantValid = 1'b0;
      grantId    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(rrPtr_q) + k;
         if (idx >= N) idx = idx - N;
         if (req_i[idx]) begin
            grantValid = 1'b1;
            grantId    = IDW'(idx);
         end
      end
   end

   assign selX = x_bus_i[int'(grantId)*W +: W];
   assign selY = y_bus_i[int'(grantId)*W +: W];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rrPtr_q    <= '0;
         curId_q    <= '0;
         resId_q    <= '0;
         divX_q     <= '0;
         divY_q     <= '0;
         resQuot_q  <= '0;
         resRem_q   <= '0;
         resDz_q    <= 1'b0;
         ack_q      <= '0;
         divStart_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rrPtr_q    <= rrPtr_d;
         curId_q    <= curId_d;
         resId_q    <= resId_d;
         divX_q     <= divX_d;
         divY_q     <= divY_d;
         resQuot_q  <= resQuot_d;
         resRem_q   <= resRem_d;
         resDz_q    <= resDz_d;
         ack_q      <= ack_d;
         divStart_q <= divStart_d;
      end
   end

   // Completion relies only on the latency counter; the core's done flag may be sticky.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rrPtr_d    = rrPtr_q;
      curId_d    = curId_q;
      resId_d    = resId_q;
      divX_d     = divX_q;
      divY_d     = divY_q;
      resQuot_d  = resQuot_q;
      resRem_d   = resRem_q;
      resDz_d    = resDz_q;
      ack_d      = '0;
      divStart_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (grantValid) begin
               curId_d = grantId;
               divX_d  = selX;
               divY_d  = selY;
               if (selY == '0) begin
                  resQuot_d = '1;
                  resRem_d  = selX;
                  resDz_d   = 1'b1;
                  state_d   = RESP;
               end else begin
                  divStart_d = 1'b1;
                  state_d    = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CW'(DIV_LAT - 1)) begin
               resQuot_d = div_q_i;
               resRem_d  = div_r_i;
               resDz_d   = 1'b0;
               state_d   = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            ack_d   = N'(1) << curId_q;
            resId_d = curId_q;
            rrPtr_d = (curId_q == IDW'(N - 1)) ? '0 : curId_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ack_o       = ack_q;
   assign res_q_o     = resQuot_q;
   assign res_r_o     = resRem_q;
   assign res_id_o    = resId_q;
   assign res_dz_o    = resDz_q;
   assign busy_o      = (state_q != IDLE);
   assign div_start_o = divStart_q;
   assign div_x_o     = divX_q;
   assign div_y_o     = divY_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a behavioural divider core.
// The core only presents correct results once its latency has elapsed, so early captures show up as garbage.
module tb_div_share_ctrl;

   localparam int N       = 4;
   localparam int W       = 16;
   localparam int DIV_LAT = 16;
   localparam int IDW     = 2;
   localparam int LAT_NORM = DIV_LAT + 3;
   localparam int LAT_DZ   = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N*W-1:0] xBus;
   logic [N*W-1:0] yBus;
   logic [N-1:0]   ack;
   logic [W-1:0]   resQ;
   logic [W-1:0]   resR;
   logic [IDW-1:0] resId;
   logic           resDz;
   logic           busy;
   logic           divStart;
   logic [W-1:0]   divX;
   logic [W-1:0]   divY;
   logic [W-1:0]   coreQ;
   logic [W-1:0]   coreR;

   int total = 0;
   int bad   = 0;
   int startCount = 0;
   int ackCount [N];

   always #5 clk = ~clk;

   div_share_ctrl #(.N(N), .W(W), .DIV_LAT(DIV_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req),
      .x_bus_i     (xBus),
      .y_bus_i     (yBus),
      .ack_o       (ack),
      .res_q_o     (resQ),
      .res_r_o     (resR),
      .res_id_o    (resId),
      .res_dz_o    (resDz),
      .busy_o      (busy),
      .div_start_o (divStart),
      .div_x_o     (divX),
      .div_y_o     (divY),
      .div_q_i     (coreQ),
      .div_r_i     (coreR)
   );

   // Core model: results become valid DIV_LAT-1 edges after it samples start.
   logic [W-1:0] mX, mY;
   int           mCnt;
   logic         mRun;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mX <= '0; mY <= '0; mCnt <= 0; mRun <= 1'b0;
      end else if (divStart) begin
         mX <= divX; mY <= divY; mCnt <= 0; mRun <= 1'b1;
      end else if (mRun && mCnt < 1000) begin
         mCnt <= mCnt + 1;
      end
   end

   always_comb begin
      coreQ = 16'hDEAD;
      coreR = 16'hBEEF;
      if (mRun && mCnt >= DIV_LAT - 1 && mY != '0) begin
         coreQ = mX / mY;
         coreR = mX % mY;
      end
   end

   initial for (int i = 0; i < N; i++) ackCount[i] = 0;

   always @(posedge clk) begin
      if (divStart) startCount++;
      for (int i = 0; i < N; i++) if (ack[i]) ackCount[i]++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int id, input logic [W-1:0] x, input logic [W-1:0] y);
      xBus[id*W +: W] = x;
      yBus[id*W +: W] = y;
      req[id]         = 1'b1;
   endtask

   task automatic waitAck(output int edges, output logic [N-1:0] seen);
      edges = 0;
      seen  = '0;
      while (edges < 40 && seen == '0) begin
         @(posedge clk);
         #1;
         edges++;
         seen = ack;
      end
      if (seen == '0) checkOutput("ack timeout", 32'd0, 32'd1);
   endtask

   task automatic checkResult(input string tag, input logic [N-1:0] seen, input int id,
                              input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
      checkOutput({tag, " ack"}, 32'(seen), 32'(1 << id));
      checkOutput({tag, " q"},   32'(resQ), 32'(q));
      checkOutput({tag, " r"},   32'(resR), 32'(r));
      checkOutput({tag, " id"},  32'(resId), 32'(id));
      checkOutput({tag, " dz"},  32'(resDz), 32'(dz));
   endtask

   int           edges;
   int           s0;
   logic [N-1:0] seen;
   int           expOrder [5] = '{0, 1, 2, 3, 0};
   logic [W-1:0] expQ [4]     = '{16'd10, 16'd9, 16'd12, 16'd255};
   logic [W-1:0] expR [4]     = '{16'd0, 16'd5, 16'd34, 16'd255};

   initial begin
      req   = '0;
      xBus  = '0;
      yBus  = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset ack", 32'(ack), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset start", 32'(divStart), 32'd0);
      checkOutput("reset res_q", 32'(resQ), 32'd0);
      checkOutput("reset div_x", 32'(divX), 32'd0);
      reset = 1'b0;

      // Basic divide with exact latency and a single start pulse.
      @(negedge clk);
      s0 = startCount;
      applyStimulus(0, 16'd100, 16'd7);
      waitAck(edges, seen);
      req[0] = 1'b0;
      checkOutput("t1 latency", 32'(edges), 32'(LAT_NORM));
      checkResult("t1", seen, 0, 16'd14, 16'd2, 1'b0);
      checkOutput("t1 starts", 32'(startCount - s0), 32'd1);

      // Divide by zero bypasses the core.
      @(negedge clk);
      s0 = startCount;
      applyStimulus(2, 16'd55, 16'd0);
      waitAck(edges, seen);
      req[2] = 1'b0;
      checkOutput("t2 latency", 32'(edges), 32'(LAT_DZ));
      checkResult("t2", seen, 2, 16'hFFFF, 16'd55, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t2 starts", 32'(startCount - s0), 32'd0);
      checkOutput("t2 hold q", 32'(resQ), 32'hFFFF);

      // Requester drops req mid-operation; ack still arrives on time.
      @(negedge clk);
      applyStimulus(3, 16'd1000, 16'd10);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("t6 busy", 32'(busy), 32'd1);
      req[3] = 1'b0;
      waitAck(edges, seen);
      checkOutput("t6 latency", 32'(edges), 32'(LAT_NORM - 5));
      checkResult("t6", seen, 3, 16'd100, 16'd0, 1'b0);

      @(negedge clk);
      applyStimulus(0, 16'd9, 16'd4);
      applyStimulus(2, 16'd30, 16'd3);
      waitAck(edges, seen);
      req[0] = 1'b0;
      checkResult("t6 next", seen, 0, 16'd2, 16'd1, 1'b0);
      waitAck(edges, seen);
      req[2] = 1'b0;
      checkResult("t6 after", seen, 2, 16'd10, 16'd0, 1'b0);

      // Operand boundaries.
      @(negedge clk);
      applyStimulus(1, 16'hFFFF, 16'd1);
      waitAck(edges, seen);
      req[1] = 1'b0;
      checkResult("t4 max", seen, 1, 16'hFFFF, 16'd0, 1'b0);
      @(negedge clk);
      applyStimulus(1, 16'd5, 16'd9);
      waitAck(edges, seen);
      req[1] = 1'b0;
      checkResult("t4 small", seen, 1, 16'd0, 16'd5, 1'b0);

      // Bring the pointer back to 0 before the fairness run.
      @(negedge clk);
      applyStimulus(3, 16'd7, 16'd2);
      waitAck(edges, seen);
      req[3] = 1'b0;
      checkResult("t3 prep", seen, 3, 16'd3, 16'd1, 1'b0);

      // All four requesting continuously: strict rotation.
      @(negedge clk);
      applyStimulus(0, 16'd50, 16'd5);
      applyStimulus(1, 16'd77, 16'd8);
      applyStimulus(2, 16'd1234, 16'd100);
      applyStimulus(3, 16'hFFFF, 16'd256);
      for (int s = 0; s < 5; s++) begin
         waitAck(edges, seen);
         if (s == 4) req = '0;
         checkResult($sformatf("t3 svc%0d", s), seen, expOrder[s],
                     expQ[expOrder[s]], expR[expOrder[s]], 1'b0);
         if (s < 4) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("t3 busy%0d", s), 32'(busy), 32'd1);
         end
      end

      // Reset in the middle of a wait aborts without an ack.
      @(negedge clk);
      applyStimulus(1, 16'd200, 16'd9);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t5 busy", 32'(busy), 32'd1);
      s0 = ackCount[1];
      #2;
      reset = 1'b1;
      #1;
      checkOutput("t5 ack", 32'(ack), 32'd0);
      checkOutput("t5 busy rst", 32'(busy), 32'd0);
      checkOutput("t5 start", 32'(divStart), 32'd0);
      checkOutput("t5 res_q", 32'(resQ), 32'd0);
      checkOutput("t5 res_r", 32'(resR), 32'd0);
      checkOutput("t5 res_id", 32'(resId), 32'd0);
      checkOutput("t5 div_x", 32'(divX), 32'd0);
      checkOutput("t5 div_y", 32'(divY), 32'd0);
      req[1] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      checkOutput("t5 no ack", 32'(ackCount[1] - s0), 32'd0);
      @(negedge clk);
      applyStimulus(1, 16'd200, 16'd9);
      waitAck(edges, seen);
      req[1] = 1'b0;
      checkOutput("t5 latency", 32'(edges), 32'(LAT_NORM));
      checkResult("t5 redo", seen, 1, 16'd22, 16'd2, 1'b0);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
